// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle sequencer and the datapath/memory side.
// Memory handshake: mem_req is held high until the cycle mem_ready is seen; a transfer completes in the cycle both are high.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             mem_req;
  logic             memwrite;
  logic             ir_en;
  logic             pc_en;
  logic [2:0]       op;
  logic             alusrc;
  logic             regdst;
  logic             mem2reg;
  logic             regwrite;
  logic             busy;
  logic             halted;
  logic [1:0]       err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       dbg_state;

  modport master (
    input  run, opcode, funct, mem_ready,
    output mem_req, memwrite, ir_en, pc_en, op, alusrc, regdst, mem2reg,
           regwrite, busy, halted, err, retired, dbg_state
  );

  modport slave (
    output run, opcode, funct, mem_ready,
    input  mem_req, memwrite, ir_en, pc_en, op, alusrc, regdst, mem2reg,
           regwrite, busy, halted, err, retired, dbg_state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset sequencer: one state per datapath phase, shared memory handshake,
// error halt on illegal instruction or memory timeout, retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0]  OPC_R    = 6'h00;
  localparam logic [5:0]  OPC_LW   = 6'h23;
  localparam logic [5:0]  OPC_SW   = 6'h2B;
  localparam logic [5:0]  OPC_ADDI = 6'h08;
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       mem_req_q, mem_req_d;
  logic       memwrite_q, memwrite_d;
  logic [2:0] op_q, op_d;
  logic       alusrc_q, alusrc_d;
  logic       regdst_q, regdst_d;
  logic       mem2reg_q, mem2reg_d;
  logic       regwrite_q, regwrite_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       fetch_done;

  function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_R:                    ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                                     (fn == 6'h25) || (fn == 6'h2A);
      OPC_LW, OPC_SW, OPC_ADDI: ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      6'h22:   a = 3'b110;
      6'h24:   a = 3'b000;
      6'h25:   a = 3'b001;
      6'h2A:   a = 3'b111;
      default: a = 3'b010;
    endcase
    return a;
  endfunction

  assign fetch_done = (state_q == S_FETCH) && bus.mem_ready;

  // Next state, latched instruction fields, timeout counter, error and retire count.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          tmo_d   = '0;
        end
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 2'b10;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_DECODE: begin
        opcode_d = bus.opcode;
        funct_d  = bus.funct;
        if (is_legal(bus.opcode, bus.funct)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = 2'b01;
        end
      end
      S_EXEC: begin
        if ((opcode_q == OPC_LW) || (opcode_q == OPC_SW)) begin
          state_d = S_MEM;
          tmo_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (opcode_q == OPC_SW) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = bus.run ? S_FETCH : S_IDLE;
            tmo_d     = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 2'b10;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = bus.run ? S_FETCH : S_IDLE;
        tmo_d     = '0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the state being entered, so they are registered alongside it.
  always_comb begin
    mem_req_d  = 1'b0;
    memwrite_d = 1'b0;
    op_d       = 3'b000;
    alusrc_d   = 1'b0;
    regdst_d   = 1'b0;
    mem2reg_d  = 1'b0;
    regwrite_d = 1'b0;
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d   = (state_d == S_HALT);
    case (state_d)
      S_FETCH: mem_req_d = 1'b1;
      S_EXEC, S_WB: begin
        if (opcode_d == OPC_R) begin
          op_d     = r_alu(funct_d);
          regdst_d = 1'b1;
        end else begin
          op_d     = 3'b010;
          alusrc_d = 1'b1;
        end
        mem2reg_d  = (state_d == S_WB) && (opcode_d == OPC_LW);
        regwrite_d = (state_d == S_WB);
      end
      S_MEM: begin
        mem_req_d  = 1'b1;
        memwrite_d = (opcode_d == OPC_SW);
        op_d       = 3'b010;
        alusrc_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      funct_q    <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      retired_q  <= '0;
      mem_req_q  <= 1'b0;
      memwrite_q <= 1'b0;
      op_q       <= 3'b000;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      mem2reg_q  <= 1'b0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      retired_q  <= retired_d;
      mem_req_q  <= mem_req_d;
      memwrite_q <= memwrite_d;
      op_q       <= op_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      mem2reg_q  <= mem2reg_d;
      regwrite_q <= regwrite_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.memwrite  = memwrite_q;
  assign bus.ir_en     = fetch_done;
  assign bus.pc_en     = fetch_done;
  assign bus.op        = op_q;
  assign bus.alusrc    = alusrc_q;
  assign bus.regdst    = regdst_q;
  assign bus.mem2reg   = mem2reg_q;
  assign bus.regwrite  = regwrite_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;
  assign bus.retired   = retired_q;
  assign bus.dbg_state = state_q;

endmodule
